y86_decode_ctrl: RTL and testbench
==================================

Y86_DECODE_CTRL -- requirements
Module: y86_decode_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 f_icode/f_ifun/f_rA/f_rB/f_stat  input  4 each  fetched instruction fields and status.
REQ-005 f_valC/f_valP  input  64 each  fetched constant and next PC.
REQ-006 rf_flat  input  960  register file contents; reg i = bits [64i+63:64i], i=0..14.
REQ-007 e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  input  4 each  forwarding destination IDs.
REQ-008 e_valE, M_valE, m_valM, W_valE, W_valM  input  64 each  forwarding values, paired in REQ-007 order.
REQ-009 E_icode/E_dstM/M_icode/m_stat/W_stat  input  4 each; e_cnd  input  1  downstream state for hazard control.
REQ-010 D_icode/D_ifun/D_rA/D_rB/D_stat  output  4 each; D_valC/D_valP  output  64 each  D pipeline register.
REQ-011 d_icode/d_ifun/d_stat/d_srcA/d_srcB/d_dstE/d_dstM  output  4 each; d_valC/d_valA/d_valB  output  64 each  decode results.
REQ-012 F_stall/D_stall/D_bubble/E_bubble/M_bubble/W_stall/set_cc  output  1 each  pipeline control.

Function
REQ-013 Encodings: icode 0 halt,1 nop,2 rrmovq/cmov,3 irmovq,4 rmmovq,5 mrmovq,6 OPq,7 jXX,8 call,9 ret,A pushq,B popq; reg 4=%rsp, F=none; stat 1 AOK, 2 HLT, 3 ADR, 4 INS; exception = stat in {2,3,4}.
REQ-014 D register, rising edge, priority: reset -> bubble; else D_stall -> hold all fields; else D_bubble -> bubble; else load f_* fields.
REQ-015 Bubble value: icode=1, ifun=0, rA=rB=F, valC=valP=0, stat=1.
REQ-016 d_icode=D_icode, d_ifun=D_ifun, d_valC=D_valC, d_stat=D_stat, combinationally.
REQ-017 d_srcA = D_rA for icode 2,4,6,A; 4 for 9,B; else F.
REQ-018 d_srcB = D_rB for icode 4,5,6; 4 for 8,9,A,B; else F.
REQ-019 d_dstE = D_rB for icode 2,3,6; 4 for 8,9,A,B; else F (cmov condition resolved downstream).
REQ-020 d_dstM = D_rA for icode 5,B; else F.
REQ-021 d_valA: D_valP if icode 7 or 8; else first match with d_srcA != F of e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE; else reg[d_srcA]; 0 when d_srcA=F.
REQ-022 d_valB: same priority chain keyed on d_srcB, no valP option; 0 when d_srcB=F.
REQ-023 load_use = (E_icode in {5,B}) AND E_dstM != F AND (E_dstM==d_srcA OR E_dstM==d_srcB); ret_in = 9 in {D_icode,E_icode,M_icode}; mispred = E_icode==7 AND !e_cnd.
REQ-024 F_stall = load_use OR ret_in; D_stall = load_use.
REQ-025 D_bubble = mispred OR (ret_in AND !load_use); E_bubble = mispred OR load_use.
REQ-026 M_bubble = m_stat or W_stat exception; W_stall = W_stat exception.
REQ-027 set_cc = E_icode==6 AND neither m_stat nor W_stat exception.
REQ-028 All control outputs and d_* outputs purely combinational; D_stall and D_bubble never both 1 (stall wins if forced).

Reset
REQ-029 reset at rising edge loads the bubble of REQ-015 into the D register regardless of stall/bubble.
REQ-030 After reset with idle downstream inputs (icodes 1, stats 1): all control outputs 0, d_srcA=d_srcB=d_dstE=d_dstM=F, d_valA=d_valB=0.

Verification
REQ-031 Load f: icode 6, rA=2, rB=3, no forwarding, reg2=5, reg3=7 -> next cycle d_srcA=2, d_srcB=3, d_dstE=3, d_valA=5, d_valB=7, set_cc 0 until E_icode=6.
REQ-032 D holds OPq srcA=2; e_dstE=2,e_valE=9 and W_dstE=2,W_valE=4 -> d_valA=9 (execute wins).
REQ-033 E_icode=5, E_dstM=3, D OPq reading reg3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; D register holds next edge.
REQ-034 E_icode=7, e_cnd=0 -> D_bubble=E_bubble=1; next edge D_icode=1.
REQ-035 D_icode=9 -> F_stall=1, D_bubble=1; W_stat=2 -> W_stall=1, M_bubble=1, set_cc=0.
REQ-036 reset asserted while D_stall=1 -> D_icode=1, D_stat=1 next edge.

Source files
------------

// File: rtl/y86_decode_ctrl.sv
// Y86-64 pipeline decode stage: D pipeline register, source/destination selection,
// operand forwarding and the hazard-control logic for the whole pipeline.
module y86_decode_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   f_icode,
  input  logic [3:0]   f_ifun,
  input  logic [3:0]   f_rA,
  input  logic [3:0]   f_rB,
  input  logic [3:0]   f_stat,
  input  logic [63:0]  f_valC,
  input  logic [63:0]  f_valP,
  input  logic [959:0] rf_flat,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   M_dstE,
  input  logic [3:0]   M_dstM,
  input  logic [3:0]   W_dstE,
  input  logic [3:0]   W_dstM,
  input  logic [63:0]  e_valE,
  input  logic [63:0]  M_valE,
  input  logic [63:0]  m_valM,
  input  logic [63:0]  W_valE,
  input  logic [63:0]  W_valM,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_dstM,
  input  logic [3:0]   M_icode,
  input  logic [3:0]   m_stat,
  input  logic [3:0]   W_stat,
  input  logic         e_cnd,
  output logic [3:0]   D_icode,
  output logic [3:0]   D_ifun,
  output logic [3:0]   D_rA,
  output logic [3:0]   D_rB,
  output logic [3:0]   D_stat,
  output logic [63:0]  D_valC,
  output logic [63:0]  D_valP,
  output logic [3:0]   d_icode,
  output logic [3:0]   d_ifun,
  output logic [3:0]   d_stat,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  output logic [3:0]   d_dstE,
  output logic [3:0]   d_dstM,
  output logic [63:0]  d_valC,
  output logic [63:0]  d_valA,
  output logic [63:0]  d_valB,
  output logic         F_stall,
  output logic         D_stall,
  output logic         D_bubble,
  output logic         E_bubble,
  output logic         M_bubble,
  output logic         W_stall,
  output logic         set_cc
);

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  logic load_use, ret_in, mispred, m_exc, w_exc;

  // Reset takes priority over stall so a stalled pipeline can still be flushed.
  always_ff @(posedge clk) begin
    if (reset || (!D_stall && D_bubble)) begin
      D_icode <= 4'h1;
      D_ifun  <= 4'h0;
      D_rA    <= R_NONE;
      D_rB    <= R_NONE;
      D_stat  <= 4'h1;
      D_valC  <= 64'd0;
      D_valP  <= 64'd0;
    end else if (!D_stall) begin
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_rA;
      D_rB    <= f_rB;
      D_stat  <= f_stat;
      D_valC  <= f_valC;
      D_valP  <= f_valP;
    end
  end

  assign d_icode = D_icode;
  assign d_ifun  = D_ifun;
  assign d_stat  = D_stat;
  assign d_valC  = D_valC;

  always_comb begin
    d_srcA = R_NONE;
    d_srcB = R_NONE;
    d_dstE = R_NONE;
    d_dstM = R_NONE;
    case (D_icode)
      4'h2: begin d_srcA = D_rA; d_dstE = D_rB; end
      4'h3: d_dstE = D_rB;
      4'h4: begin d_srcA = D_rA; d_srcB = D_rB; end
      4'h5: begin d_srcB = D_rB; d_dstM = D_rA; end
      4'h6: begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      4'h8: begin d_srcB = R_RSP; d_dstE = R_RSP; end
      4'h9: begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; end
      4'hA: begin d_srcA = D_rA; d_srcB = R_RSP; d_dstE = R_RSP; end
      4'hB: begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; d_dstM = D_rA; end
      default: ;
    endcase
  end

  // Forwarding priority: youngest producer first, memory-load result ahead of
  // the ALU result in the same stage.
  always_comb begin
    d_valA = 64'd0;
    if (D_icode == 4'h7 || D_icode == 4'h8)  d_valA = D_valP;
    else if (d_srcA == R_NONE)               d_valA = 64'd0;
    else if (d_srcA == e_dstE)               d_valA = e_valE;
    else if (d_srcA == M_dstM)               d_valA = m_valM;
    else if (d_srcA == M_dstE)               d_valA = M_valE;
    else if (d_srcA == W_dstM)               d_valA = W_valM;
    else if (d_srcA == W_dstE)               d_valA = W_valE;
    else                                     d_valA = rf_flat[{d_srcA, 6'd0} +: 64];
  end

  always_comb begin
    d_valB = 64'd0;
    if (d_srcB == R_NONE)                    d_valB = 64'd0;
    else if (d_srcB == e_dstE)               d_valB = e_valE;
    else if (d_srcB == M_dstM)               d_valB = m_valM;
    else if (d_srcB == M_dstE)               d_valB = M_valE;
    else if (d_srcB == W_dstM)               d_valB = W_valM;
    else if (d_srcB == W_dstE)               d_valB = W_valE;
    else                                     d_valB = rf_flat[{d_srcB, 6'd0} +: 64];
  end

  assign load_use = (E_icode == 4'h5 || E_icode == 4'hB) && (E_dstM != R_NONE) &&
                    (E_dstM == d_srcA || E_dstM == d_srcB);
  assign ret_in   = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  assign mispred  = (E_icode == 4'h7) && !e_cnd;
  assign m_exc    = (m_stat == 4'h2) || (m_stat == 4'h3) || (m_stat == 4'h4);
  assign w_exc    = (W_stat == 4'h2) || (W_stat == 4'h3) || (W_stat == 4'h4);

  // mispred and load_use need different E_icode values, so D_stall and
  // D_bubble cannot both assert.
  assign F_stall  = load_use || ret_in;
  assign D_stall  = load_use;
  assign D_bubble = mispred || (ret_in && !load_use);
  assign E_bubble = mispred || load_use;
  assign M_bubble = m_exc || w_exc;
  assign W_stall  = w_exc;
  assign set_cc   = (E_icode == 4'h6) && !m_exc && !w_exc;

endmodule

// File: tb/tb_y86_decode_ctrl.sv
// Randomized bench for y86_decode_ctrl: a stimulus process drives inputs and
// queues expected outputs from a reference model; a monitor pops and compares.
module tb_y86_decode_ctrl;

  localparam int N_CYCLES = 2000;
  localparam logic [3:0] NONE = 4'hF;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   f_icode, f_ifun, f_rA, f_rB, f_stat;
  logic [63:0]  f_valC, f_valP;
  logic [959:0] rf_flat;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]   E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic         e_cnd;
  logic [3:0]   D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0]  D_valC, D_valP;
  logic [3:0]   d_icode, d_ifun, d_stat, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0]  d_valC, d_valA, d_valB;
  logic         F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;

  y86_decode_ctrl dut (
    .clk(clk), .reset(reset),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB), .f_stat(f_stat),
    .f_valC(f_valC), .f_valP(f_valP), .rf_flat(rf_flat),
    .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
    .E_icode(E_icode), .E_dstM(E_dstM), .M_icode(M_icode), .m_stat(m_stat),
    .W_stat(W_stat), .e_cnd(e_cnd),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] icode, ifun, rA, rB, stat;
    logic [63:0] valC, valP;
  } dreg_t;

  typedef struct packed {
    dreg_t      d;
    logic [3:0] srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB;
    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;
  } exp_t;

  exp_t  exp_q[$];
  dreg_t model_d;
  logic [63:0] rf [15];
  int n_checks = 0;
  int n_err = 0;
  bit stim_done = 1'b0;

  function automatic dreg_t bubble();
    dreg_t b;
    b.icode = 4'h1; b.ifun = 4'h0; b.rA = NONE; b.rB = NONE; b.stat = 4'h1;
    b.valC = 64'd0; b.valP = 64'd0;
    return b;
  endfunction

  function automatic bit is_exc(input logic [3:0] s);
    return s inside {4'h2, 4'h3, 4'h4};
  endfunction

  // Operand value: the newest in-flight result for the register, else the file.
  function automatic logic [63:0] operand(input logic [3:0] src);
    logic [3:0]  dst[5];
    logic [63:0] val[5];
    dst = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    val = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == NONE) return 64'd0;
    for (int k = 0; k < 5; k++)
      if (dst[k] == src) return val[k];
    return rf[src];
  endfunction

  function automatic exp_t predict(input dreg_t d);
    exp_t e;
    bit lu, ret_in, mis;
    e.d    = d;
    e.srcA = (d.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? d.rA :
             (d.icode inside {4'h9, 4'hB}) ? 4'h4 : NONE;
    e.srcB = (d.icode inside {4'h4, 4'h5, 4'h6}) ? d.rB :
             (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : NONE;
    e.dstE = (d.icode inside {4'h2, 4'h3, 4'h6}) ? d.rB :
             (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : NONE;
    e.dstM = (d.icode inside {4'h5, 4'hB}) ? d.rA : NONE;
    e.valA = (d.icode inside {4'h7, 4'h8}) ? d.valP : operand(e.srcA);
    e.valB = operand(e.srcB);
    lu     = (E_icode inside {4'h5, 4'hB}) && E_dstM != NONE &&
             (E_dstM == e.srcA || E_dstM == e.srcB);
    ret_in = (d.icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mis    = (E_icode == 4'h7) && !e_cnd;
    e.f_stall  = lu || ret_in;
    e.d_stall  = lu;
    e.d_bubble = mis || (ret_in && !lu);
    e.e_bubble = mis || lu;
    e.m_bubble = is_exc(m_stat) || is_exc(W_stat);
    e.w_stall  = is_exc(W_stat);
    e.set_cc   = (E_icode == 4'h6) && !is_exc(m_stat) && !is_exc(W_stat);
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [3:0] rand_reg();
    int r = $urandom_range(0, 9);
    if (r < 3) return NONE;
    if (r < 8) return 4'($urandom_range(0, 4));
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [3:0] rand_stat();
    return ($urandom_range(0, 9) < 8) ? 4'h1 : 4'($urandom_range(0, 4));
  endfunction

  function automatic logic [3:0] rand_down_icode();
    logic [3:0] pick[7];
    pick = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h0};
    pick[6] = 4'($urandom_range(0, 15));
    return pick[$urandom_range(0, 6)];
  endfunction

  task automatic drive_random(input bit idle);
    f_icode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
    f_ifun  = 4'($urandom_range(0, 15));
    f_rA    = rand_reg();
    f_rB    = rand_reg();
    f_stat  = rand_stat();
    f_valC  = {$urandom, $urandom};
    f_valP  = {$urandom, $urandom};
    for (int i = 0; i < 15; i++) begin
      rf[i] = {$urandom, $urandom};
      rf_flat[i*64 +: 64] = rf[i];
    end
    e_dstE = rand_reg(); M_dstE = rand_reg(); M_dstM = rand_reg();
    W_dstE = rand_reg(); W_dstM = rand_reg();
    e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
    m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
    W_valM = {$urandom, $urandom};
    E_icode = rand_down_icode();
    M_icode = ($urandom_range(0, 7) == 0) ? 4'h9 : rand_down_icode();
    E_dstM  = rand_reg();
    m_stat  = rand_stat();
    W_stat  = rand_stat();
    e_cnd   = 1'($urandom_range(0, 1));
    if (idle) begin
      E_icode = 4'h1; M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1; e_cnd = 1'b1;
      E_dstM = NONE; e_dstE = NONE; M_dstE = NONE; M_dstM = NONE;
      W_dstE = NONE; W_dstM = NONE;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    reset = 1'b1;
    drive_random(1'b1);
    model_d = bubble();
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      reset = (cyc < 2) || ($urandom_range(0, 32) == 0);
      drive_random(cyc == 2);
      #1;
      e = predict(model_d);
      exp_q.push_back(e);
      @(posedge clk);
      if (reset)               model_d = bubble();
      else if (e.d_stall)      model_d = model_d;
      else if (e.d_bubble)     model_d = bubble();
      else begin
        model_d.icode = f_icode; model_d.ifun = f_ifun; model_d.rA = f_rA;
        model_d.rB = f_rB; model_d.stat = f_stat;
        model_d.valC = f_valC; model_d.valP = f_valP;
      end
    end
    stim_done = 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("D_icode", D_icode, e.d.icode);  chk("D_ifun", D_ifun, e.d.ifun);
        chk("D_rA", D_rA, e.d.rA);           chk("D_rB", D_rB, e.d.rB);
        chk("D_stat", D_stat, e.d.stat);
        chk("D_valC", D_valC, e.d.valC);     chk("D_valP", D_valP, e.d.valP);
        chk("d_icode", d_icode, e.d.icode);  chk("d_ifun", d_ifun, e.d.ifun);
        chk("d_stat", d_stat, e.d.stat);     chk("d_valC", d_valC, e.d.valC);
        chk("d_srcA", d_srcA, e.srcA);       chk("d_srcB", d_srcB, e.srcB);
        chk("d_dstE", d_dstE, e.dstE);       chk("d_dstM", d_dstM, e.dstM);
        chk("d_valA", d_valA, e.valA);       chk("d_valB", d_valB, e.valB);
        chk("F_stall", F_stall, e.f_stall);  chk("D_stall", D_stall, e.d_stall);
        chk("D_bubble", D_bubble, e.d_bubble);
        chk("E_bubble", E_bubble, e.e_bubble);
        chk("M_bubble", M_bubble, e.m_bubble);
        chk("W_stall", W_stall, e.w_stall);  chk("set_cc", set_cc, e.set_cc);
      end
    end
  end

  // ---------------- final report ----------------
  initial begin
    int guard = 0;
    while (!stim_done && guard < N_CYCLES + 100) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (!stim_done || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0",
               stim_done, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
